id_ex_pipe_stage: RTL and testbench

- Parametrised decode/execute pipeline register. It replaces the free-running decode register with one that supports stall, flush and valid tracking, and has a configurable immediate-alignment delay.
- Sits between the instruction decoder and the execute stage/ALU.
- The immediate path has its own stall-aware delay line. This lets immediate generation use a longer pipeline than the register and control fields.

---
 rtl/id_ex_pipe_stage.sv | 168 ++++++++++++++++
 tb/tb_id_ex_pipe_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_stage.sv
// Decode/execute pipeline register with stall, flush, valid tracking and a
// stall-aware immediate delay line. Optional counters: ID_EX_PERF_CNT_EN.
module id_ex_pipe_stage #(
  parameter int         WIDTH      = 32,
  parameter int         IMM_LAT    = 2,
  parameter logic [6:0] NOP_OPCODE = 7'h13,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [4:0]       r_reg1,
  input  logic [4:0]       r_reg2,
  input  logic [4:0]       wr_reg,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic [6:0]       opcode,
  input  logic [WIDTH-1:0] immediate_data,
  output logic [4:0]       r_reg1_out,
  output logic [4:0]       r_reg2_out,
  output logic [4:0]       wr_reg_out,
  output logic [2:0]       func3_out,
  output logic [6:0]       func7_out,
  output logic [6:0]       opcode_out,
  output logic [WIDTH-1:0] immediate_data_out,
  output logic             out_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [4:0]       r_reg1_q, r_reg1_d;
  logic [4:0]       r_reg2_q, r_reg2_d;
  logic [4:0]       wr_reg_q, wr_reg_d;
  logic [2:0]       func3_q, func3_d;
  logic [6:0]       func7_q, func7_d;
  logic [6:0]       opcode_q, opcode_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] imm_q [IMM_LAT];
  logic [WIDTH-1:0] imm_d [IMM_LAT];

  // Next-state selection: flush beats stall beats normal load.
  always_comb begin
    r_reg1_d = r_reg1_q;
    r_reg2_d = r_reg2_q;
    wr_reg_d = wr_reg_q;
    func3_d  = func3_q;
    func7_d  = func7_q;
    opcode_d = opcode_q;
    valid_d  = valid_q;
    for (int i = 0; i < IMM_LAT; i++) begin
      imm_d[i] = imm_q[i];
    end
    if (flush) begin
      r_reg1_d = 5'd0;
      r_reg2_d = 5'd0;
      wr_reg_d = 5'd0;
      func3_d  = 3'd0;
      func7_d  = 7'd0;
      opcode_d = NOP_OPCODE;
      valid_d  = 1'b0;
      for (int i = 0; i < IMM_LAT; i++) begin
        imm_d[i] = '0;
      end
    end else if (stall) begin
      valid_d = valid_q;
    end else begin
      if (in_valid) begin
        r_reg1_d = r_reg1;
        r_reg2_d = r_reg2;
        wr_reg_d = wr_reg;
        func3_d  = func3;
        func7_d  = func7;
        opcode_d = opcode;
        valid_d  = 1'b1;
        imm_d[0] = immediate_data;
      end else begin
        r_reg1_d = 5'd0;
        r_reg2_d = 5'd0;
        wr_reg_d = 5'd0;
        func3_d  = 3'd0;
        func7_d  = 7'd0;
        opcode_d = NOP_OPCODE;
        valid_d  = 1'b0;
        imm_d[0] = '0;
      end
      for (int i = 1; i < IMM_LAT; i++) begin
        imm_d[i] = imm_q[i-1];
      end
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg1_q <= 5'd0;
      r_reg2_q <= 5'd0;
      wr_reg_q <= 5'd0;
      func3_q  <= 3'd0;
      func7_q  <= 7'd0;
      opcode_q <= NOP_OPCODE;
      valid_q  <= 1'b0;
      for (int i = 0; i < IMM_LAT; i++) begin
        imm_q[i] <= '0;
      end
    end else begin
      r_reg1_q <= r_reg1_d;
      r_reg2_q <= r_reg2_d;
      wr_reg_q <= wr_reg_d;
      func3_q  <= func3_d;
      func7_q  <= func7_d;
      opcode_q <= opcode_d;
      valid_q  <= valid_d;
      for (int i = 0; i < IMM_LAT; i++) begin
        imm_q[i] <= imm_d[i];
      end
    end
  end

  assign r_reg1_out         = r_reg1_q;
  assign r_reg2_out         = r_reg2_q;
  assign wr_reg_out         = wr_reg_q;
  assign func3_out          = func3_q;
  assign func7_out          = func7_q;
  assign opcode_out         = opcode_q;
  assign out_valid          = valid_q;
  assign immediate_data_out = imm_q[IMM_LAT-1];

`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters; a flush edge never counts as a stall.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Directed bench for id_ex_pipe_stage (IMM_LAT=2, CNT_W=4).
module tb_id_ex_pipe_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush;
  logic [4:0]  r_reg1, r_reg2, wr_reg;
  logic [2:0]  func3;
  logic [6:0]  func7, opcode;
  logic [31:0] immediate_data;
  logic [4:0]  r_reg1_out, r_reg2_out, wr_reg_out;
  logic [2:0]  func3_out;
  logic [6:0]  func7_out, opcode_out;
  logic [31:0] immediate_data_out;
  logic        out_valid;
  logic [3:0]  stall_cnt, flush_cnt;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  id_ex_pipe_stage #(.WIDTH(32), .IMM_LAT(2), .NOP_OPCODE(7'h13), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .r_reg1(r_reg1), .r_reg2(r_reg2), .wr_reg(wr_reg), .func3(func3),
    .func7(func7), .opcode(opcode), .immediate_data(immediate_data),
    .r_reg1_out(r_reg1_out), .r_reg2_out(r_reg2_out), .wr_reg_out(wr_reg_out),
    .func3_out(func3_out), .func7_out(func7_out), .opcode_out(opcode_out),
    .immediate_data_out(immediate_data_out), .out_valid(out_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_core(input string tag, input logic [6:0] op, input logic [4:0] wr,
                          input logic v, input logic [31:0] imm);
    chk({tag, ".opcode"}, 32'(opcode_out), 32'(op));
    chk({tag, ".wr_reg"}, 32'(wr_reg_out), 32'(wr));
    chk({tag, ".valid"},  32'(out_valid),  32'(v));
    chk({tag, ".imm"},    immediate_data_out, imm);
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] wr,
                       input logic [31:0] imm);
    in_valid = v; opcode = op; wr_reg = wr; immediate_data = imm;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    r_reg1 = 5'd0; r_reg2 = 5'd0; func3 = 3'd0; func7 = 7'd0;
    drive(1'b1, 7'h33, 5'd9, 32'hFFFF_FFFF);
    step();
    chk_core("reset", 7'h13, 5'd0, 1'b0, 32'h0);
    chk("reset.r_reg1", 32'(r_reg1_out), 32'h0);
    chk("reset.stall_cnt", 32'(stall_cnt), 32'h0);
    chk("reset.flush_cnt", 32'(flush_cnt), 32'h0);
    rst = 1'b0;

    drive(1'b0, 7'h7F, 5'd31, 32'h1234_5678);
    r_reg1 = 5'd3;
    for (int i = 0; i < 3; i++) step();
    chk_core("idle", 7'h13, 5'd0, 1'b0, 32'h0);
    chk("idle.r_reg1", 32'(r_reg1_out), 32'h0);

    // Stream: fields latency 1, immediate latency 2.
    r_reg1 = 5'd1; r_reg2 = 5'd2; func3 = 3'd5; func7 = 7'h20;
    drive(1'b1, 7'h33, 5'd3, 32'h10);
    step();
    chk_core("s1", 7'h33, 5'd3, 1'b1, 32'h0);
    chk("s1.r_reg1", 32'(r_reg1_out), 32'd1);
    chk("s1.r_reg2", 32'(r_reg2_out), 32'd2);
    chk("s1.func3",  32'(func3_out),  32'd5);
    chk("s1.func7",  32'(func7_out),  32'h20);
    drive(1'b1, 7'h13, 5'd4, 32'h20);
    step();
    chk_core("s2", 7'h13, 5'd4, 1'b1, 32'h10);
    drive(1'b1, 7'h03, 5'd6, 32'h30);
    step();
    chk_core("s3", 7'h03, 5'd6, 1'b1, 32'h20);
    drive(1'b0, 7'h33, 5'd7, 32'h99);
    step();
    chk_core("s4", 7'h13, 5'd0, 1'b0, 32'h30);
    chk("s4.func7", 32'(func7_out), 32'h0);
    step();
    chk_core("s5", 7'h13, 5'd0, 1'b0, 32'h0);

    // Stall freezes fields and the delay line.
    drive(1'b1, 7'h33, 5'd5, 32'hAA);
    step();
    chk_core("ld", 7'h33, 5'd5, 1'b1, 32'h0);
    stall = 1'b1;
    drive(1'b1, 7'h03, 5'd9, 32'h55);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_core("stall", 7'h33, 5'd5, 1'b1, 32'h0);
    end
    stall = 1'b0;
    drive(1'b0, 7'h00, 5'd0, 32'h0);
    step();
    chk_core("release", 7'h13, 5'd0, 1'b0, 32'hAA);

    // Flush overrides stall and clears the delay line.
    drive(1'b1, 7'h33, 5'd7, 32'hBB);
    step();
    drive(1'b1, 7'h03, 5'd8, 32'hCC);
    step();
    chk_core("pre_flush", 7'h03, 5'd8, 1'b1, 32'hBB);
    flush = 1'b1; stall = 1'b1;
    step();
    chk_core("flush", 7'h13, 5'd0, 1'b0, 32'h0);
    flush = 1'b0; stall = 1'b0;
    drive(1'b0, 7'h00, 5'd0, 32'h0);
    step();
    chk_core("post_flush", 7'h13, 5'd0, 1'b0, 32'h0);

    // Reset during a stall with valid contents.
    drive(1'b1, 7'h33, 5'd4, 32'hDD);
    step();
    step();
    chk_core("pre_rst", 7'h33, 5'd4, 1'b1, 32'hDD);
    stall = 1'b1; rst = 1'b1;
    step();
    chk_core("rst_stall", 7'h13, 5'd0, 1'b0, 32'h0);
    chk("rst_stall.r_reg1", 32'(r_reg1_out), 32'h0);
    chk("rst_stall.stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_stall.flush_cnt", 32'(flush_cnt), 32'h0);
    rst = 1'b0; stall = 1'b0;
    drive(1'b0, 7'h00, 5'd0, 32'h0);
    step();
    chk_core("post_rst", 7'h13, 5'd0, 1'b0, 32'h0);

    // Counters: 20 stalls saturate a 4-bit counter, then 2 flushes.
    stall = 1'b1;
    for (int i = 0; i < 20; i++) step();
    stall = 1'b0; flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    step();
`ifdef ID_EX_PERF_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'd15);
    chk("flush_cnt", 32'(flush_cnt), 32'd2);
`else
    chk("stall_cnt", 32'(stall_cnt), 32'd0);
    chk("flush_cnt", 32'(flush_cnt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
